aes_decrypt_iter: RTL and testbench
===================================

# aes_decrypt_iter

Iterative AES-128 decryption engine, the inverse counterpart of the team's table-driven encryption rounds. It accepts one 128-bit ciphertext block per transaction and applies the standard inverse cipher over 10 rounds, one round per clock. Round keys come from an external key store indexed by this block. It sits between the ciphertext ingress FIFO and the plaintext egress path, with valid/ready handshakes on both sides.

## Interface
- No parameters; AES-128 only (10 rounds, 128-bit state).
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  ciphertext block offered.
- in_ready  out  1  block can accept ciphertext.
- ct_in  in  128  ciphertext; bits [127:120] are byte 0, packed column-major as {col0, col1, col2, col3}.
- key_idx  out  4  encryption round-key index requested, 0..10.
- round_key  in  128  encryption round key for key_idx; combinational, valid in the same cycle; same packing as ct_in.
- out_valid  out  1  plaintext available.
- out_ready  in  1  downstream accepts plaintext.
- pt_out  out  128  plaintext, same packing.

## Operation
- FSM states: IDLE, ROUND, DONE.
- **IDLE:**
  - in_ready=1, key_idx=10.
  - On in_valid: state_reg <= ct_in ^ round_key (key 10); rnd <= 9; go to ROUND.
- **ROUND:**
  - in_ready=0, key_idx=rnd.
  - Each cycle: t = InvSubBytes(InvShiftRows(state_reg)) ^ round_key.
  - rnd != 0: state_reg <= InvMixColumns(t); rnd <= rnd-1.
  - rnd == 0: pt_out <= t; go to DONE.
- **DONE:**
  - out_valid=1, in_ready=0, key_idx=10.
  - pt_out is held stable until out_valid && out_ready, then go to IDLE.
- **Inverse transforms:**
  - InvShiftRows rotates row r right by r bytes.
  - InvSubBytes uses 16 inverse S-box lookups, combinational and not registered.
  - InvMixColumns multiplies each column by {0e,0b,0d,09} over GF(2^8) with polynomial 0x11b.
- rnd is a 4-bit down-counter; it never wraps, because the exit is taken at 0.
- **No overlap:** a new block is accepted only in IDLE. Back-to-back throughput is one block per 12 cycles when out_ready is held high.
- **Reset** (any state, including mid-round): in the next cycle FSM=IDLE, out_valid=0, pt_out=0, rnd=0, key_idx=10. The in-flight block is discarded and no output is produced for it.
- rst takes priority over every handshake in the same cycle.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, pt_out=0, key_idx=10.
- Accept at cycle T (in_valid && in_ready sampled high):
  - T+1..T+10: ROUND, with key_idx = 9,8,…,0.
  - T+11: out_valid=1 with the final pt_out.
  - Latency is 11 cycles from accept to out_valid.
- If out_ready is high at T+11, the block is in IDLE at T+12 and can accept again there.
- in_ready and key_idx are decoded from FSM state and rnd only, with no combinational path from inputs. out_valid and pt_out are registered.
- in_valid while not in IDLE is ignored. ct_in needs to be valid only in the accept cycle.
- round_key must follow key_idx combinationally within the cycle.

## Configuration
- `AES_DEC_ZEROIZE_EN`
  - **Defined:** in the cycle after an output handshake, pt_out and state_reg are cleared to all-zero, so no plaintext remains in registers.
  - **Undefined:** pt_out and state_reg retain their last values after the handshake.
- Handshake timing and latency are identical either way.

## Test plan
- **FIPS-197 C.1:**
  - Stimulus: ct=69c4e0d86a7b0430d8cdb78070b4c55a, key 000102030405060708090a0b0c0d0e0f, out_ready=1.
  - Response: pt_out=00112233445566778899aabbccddeeff with out_valid at exactly T+11; key_idx sequence 10,9,…,0.
- **FIPS-197 Appendix B:**
  - Stimulus: ct=3925841d02dc09fbdc118597196a0b32, key 2b7e151628aed2a6abf7158809cf4f3c.
  - Response: pt=3243f6a8885a308d313198a2e0370734.
- **Backpressure:**
  - Stimulus: out_ready=0 for 20 cycles after out_valid rises; in_valid held high throughout with a second block.
  - Response: pt_out stable, in_ready=0, and the second block is accepted only the cycle after the out_ready=1 handshake.
- **Back-to-back:**
  - Stimulus: both vectors above queued, with out_ready=1.
  - Response: accepts 12 cycles apart; both plaintexts correct and in order.
- **Reset mid-operation:**
  - Stimulus: assert rst at T+5 for one cycle.
  - Response: no out_valid for the aborted block, in_ready=1 the cycle after rst deasserts, and the next vector decrypts correctly.
- **Zeroize (AES_DEC_ZEROIZE_EN defined):**
  - Stimulus: C.1 vector, then the output handshake.
  - Response: pt_out==0 the cycle after the handshake.
  - With the macro undefined, pt_out stays 00112233445566778899aabbccddeeff.

Source files
------------

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 inverse cipher: one round per clock, round keys fetched through key_idx.
// Optional macro AES_DEC_ZEROIZE_EN clears pt_out and the round state after each output handshake.
module aes_decrypt_iter (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ct_in,
    output logic [3:0]   key_idx,
    input  logic [127:0] round_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] pt_out
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    state_t       r_fsm;
    state_t       w_fsm_nxt;
    logic [3:0]   r_rnd;
    logic [127:0] r_blk;
    logic [127:0] r_pt;
    logic [127:0] w_isr;
    logic [127:0] w_t;
    logic [127:0] w_imc;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = '0;
        p   = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Inverse affine map, then the field inverse computed as b^254 = b^2 * b^4 * ... * b^128.
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        logic [7:0] p;
        logic [7:0] r;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        p = b;
        r = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] m0, m1, m2, m3;
        {a0, a1, a2, a3} = col;
        m0 = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
        m1 = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
        m2 = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
        m3 = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        return {m0, m1, m2, m3};
    endfunction

    // Byte (row r, col c) sits at index 4*c+r; row r is taken from column (c - r) mod 4.
    always_comb begin
        w_isr = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                w_isr[127-8*(4*c+r) -: 8] = inv_sbox(r_blk[127-8*(4*((c+4-r)%4)+r) -: 8]);
            end
        end
    end

    assign w_t   = w_isr ^ round_key;
    assign w_imc = {inv_mix_col(w_t[127:96]), inv_mix_col(w_t[95:64]),
                    inv_mix_col(w_t[63:32]),  inv_mix_col(w_t[31:0])};

    always_ff @(posedge clk) begin
        if (rst) r_fsm <= IDLE;
        else     r_fsm <= w_fsm_nxt;
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        in_ready  = 1'b0;
        key_idx   = 4'd10;
        case (r_fsm)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_fsm_nxt = ROUND;
            end
            ROUND: begin
                key_idx = r_rnd;
                if (r_rnd == 4'd0) w_fsm_nxt = DONE;
            end
            DONE: begin
                if (out_ready) w_fsm_nxt = IDLE;
            end
            default: w_fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rnd <= '0;
            r_blk <= '0;
            r_pt  <= '0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (in_valid) begin
                        r_blk <= ct_in ^ round_key;
                        r_rnd <= 4'd9;
                    end
                end
                ROUND: begin
                    if (r_rnd != 4'd0) begin
                        r_blk <= w_imc;
                        r_rnd <= r_rnd - 4'd1;
                    end else begin
                        r_pt <= w_t;
                    end
                end
                DONE: begin
`ifdef AES_DEC_ZEROIZE_EN
                    if (out_ready) begin
                        r_pt  <= '0;
                        r_blk <= '0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign out_valid = (r_fsm == DONE);
    assign pt_out    = r_pt;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Self-checking bench for aes_decrypt_iter: FIPS-197 vectors, backpressure, reset abort, random blocks.
module tb_aes_decrypt_iter;
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ct_in;
    logic [3:0]   key_idx;
    logic [127:0] round_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] pt_out;

    logic [7:0]        sbox  [256];
    logic [7:0]        isbox [256];
    logic [10:0][127:0] cur_rk;
    int                n_checks = 0;
    int                n_fail   = 0;
    int unsigned       cyc      = 0;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

    aes_decrypt_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ct_in     (ct_in),
        .key_idx   (key_idx),
        .round_key (round_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pt_out    (pt_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Key store: combinational lookup of the current key schedule.
    assign round_key = (key_idx <= 4'd10) ? cur_rk[key_idx] : '0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Carry-less product then reduction modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] b;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            s = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
            sbox[x]  = s;
            isbox[s] = 8'(x);
        end
    endtask

    function automatic logic [10:0][127:0] expand(input logic [127:0] key);
        logic [31:0]        w [44];
        logic [31:0]        t;
        logic [7:0]         rc;
        logic [10:0][127:0] rk;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k < 11; k++) rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
        return rk;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] v);
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        logic [127:0] o;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gf_mul(coef[(k - r + 4) % 4], v[127-8*(4*c+k) -: 8]);
                o[127-8*(4*c+r) -: 8] = acc;
            end
        end
        return o;
    endfunction

    // Textbook inverse cipher; InvShiftRows scatters byte (r,c) to column (c+r) mod 4.
    function automatic logic [127:0] dec_model(input logic [127:0] ct, input logic [10:0][127:0] rk);
        logic [7:0]   u [16];
        logic [127:0] v;
        v = ct ^ rk[10];
        for (int rd = 9; rd >= 0; rd--) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    u[4*((c+r)%4)+r] = isbox[v[127-8*(4*c+r) -: 8]];
            for (int i = 0; i < 16; i++) v[127-8*i -: 8] = u[i];
            v = v ^ rk[rd];
            if (rd != 0) v = inv_mix(v);
        end
        return v;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Begins and ends on a falling edge; the block is offered at entry and accepted on the next rise.
    task automatic run_block(input logic [127:0] ct, input logic [127:0] key, input int stall,
                             input logic hold_next, input logic [127:0] next_ct,
                             output int unsigned acc_cyc, output logic [127:0] got_pt);
        logic [127:0] exp_pt;
        cur_rk = expand(key);
        exp_pt = dec_model(ct, cur_rk);
        check("in_ready_idle", 128'(in_ready), 128'(1));
        check("key_idx_idle", 128'(key_idx), 128'(10));
        in_valid = 1'b1;
        ct_in    = ct;
        @(posedge clk);
        #1 acc_cyc = cyc;
        @(negedge clk);
        in_valid = hold_next;
        ct_in    = hold_next ? next_ct : rand128();
        for (int c = 1; c <= 10; c++) begin
            check("key_idx_round", 128'(key_idx), 128'(10 - c));
            check("in_ready_round", 128'(in_ready), 128'(0));
            check("out_valid_round", 128'(out_valid), 128'(0));
            @(negedge clk);
        end
        check("out_valid_lat11", 128'(out_valid), 128'(1));
        check("pt_out", pt_out, exp_pt);
        got_pt = pt_out;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("pt_hold", pt_out, exp_pt);
            check("out_valid_hold", 128'(out_valid), 128'(1));
            check("in_ready_done", 128'(in_ready), 128'(0));
            check("key_idx_done", 128'(key_idx), 128'(10));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_after_hs", 128'(out_valid), 128'(0));
        check("in_ready_after_hs", 128'(in_ready), 128'(1));
`ifdef AES_DEC_ZEROIZE_EN
        check("pt_zeroized", pt_out, '0);
`else
        check("pt_retained", pt_out, exp_pt);
`endif
    endtask

    initial begin
        int unsigned  a1, a2;
        logic [127:0] p1, p2;
        logic         saw_valid;

        build_tables();
        cur_rk    = '0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ct_in     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_pt_out", pt_out, '0);
        check("rst_key_idx", 128'(key_idx), 128'(10));

        // FIPS-197 C.1 and Appendix B back-to-back with out_ready asserted on arrival.
        run_block(CT_C1, KEY_C1, 0, 1'b0, '0, a1, p1);
        run_block(CT_B, KEY_B, 0, 1'b0, '0, a2, p2);
        check("c1_plaintext", p1, PT_C1);
        check("appB_plaintext", p2, PT_B);
        check("b2b_accept_gap", 128'(a2 - a1), 128'(12));

        // Backpressure: second block held on in_valid through a 20-cycle stall.
        run_block(CT_C1, KEY_C1, 20, 1'b1, CT_B, a1, p1);
        run_block(CT_B, KEY_B, 0, 1'b0, '0, a2, p2);
        check("bp_accept_gap", 128'(a2 - a1), 128'(32));
        check("bp_second_pt", p2, PT_B);

        // Reset five cycles after accept aborts the block.
        cur_rk   = expand(KEY_C1);
        in_valid = 1'b1;
        ct_in    = CT_C1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", 128'(in_ready), 128'(1));
        check("abort_out_valid", 128'(out_valid), 128'(0));
        check("abort_key_idx", 128'(key_idx), 128'(10));
        check("abort_pt_out", pt_out, '0);
        saw_valid = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        check("abort_no_output", 128'(saw_valid), 128'(0));
        run_block(CT_B, KEY_B, 1, 1'b0, '0, a1, p1);
        check("after_abort_pt", p1, PT_B);

        // Random keys, ciphertexts, stalls and idle gaps.
        for (int n = 0; n < 12; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_block(rand128(), rand128(), int'($urandom_range(0, 3)), 1'b0, '0, a1, p1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
